frame_compositor: RTL and testbench
===================================

Name: frame_compositor

Overview:
- Builds the red/green 8x8 frame consumed by led_matrix_driver from Tetris game state.
- Game state: locked board cells (green), active falling piece (red), and rows flagged for line-clear flashing.
- Composes into a back buffer one row per clock.
- Swaps to the front buffer only on the driver's frame boundary, so a scan never shows a half-built frame.

Parameters:
- BLINK_LOG2, default 2: flashing rows toggle visibility every 2^BLINK_LOG2 swapped frames.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request to compose a new frame; sampled only in IDLE
- frame_sync  in  1  one-cycle pulse when the driver wraps row 7->0
- locked  in  [7:0][7:0]  settled board cells; [row][col]
- piece_x  in  [3:0][2:0]  column of each of 4 piece cells
- piece_y  in  [3:0][2:0]  row of each of 4 piece cells
- piece_mask  in  4  per-cell valid
- flash_rows  in  8  rows currently being cleared
- busy  out  1  high in BUILD and WAIT_SWAP
- frame_done  out  1  one-cycle pulse after a swap
- red_array  out  [7:0][7:0]  front-buffer red plane
- green_array  out  [7:0][7:0]  front-buffer green plane

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; row counter=0; frame counter=0.
  - Front and back buffers all 0, so red_array and green_array read 0.
  - busy=0, frame_done=0.
  - Reset mid-BUILD or mid-WAIT_SWAP discards all work; no partial swap.
- States are IDLE, BUILD, WAIT_SWAP.
- IDLE:
  - start=1 at edge E0 snapshots locked, piece_*, flash_rows and the current blink phase into internal registers.
  - At the same edge: row:=0, state:=BUILD.
  - start is ignored while busy=1; it is not queued.
- BUILD:
  - At edges E1..E8, back-buffer row r (r=0..7) is written from the snapshot only; input changes after E0 have no effect.
  - Piece bit for (r,c): OR over i of piece_mask[i] && piece_y[i]==r && piece_x[i]==c. Duplicate cells are harmless.
  - green[r][c] = locked[r][c].
  - red[r][c] = piece bit for (r,c).
  - Overlap gives red=green=1 (amber), a deliberate collision indicator.
  - If flash_rows[r] && blink phase=1, both red and green for row r are 0.
  - Blink phase = frame_counter[BLINK_LOG2].
  - Row counter is 3 bits. At E8 (r=7 written) it wraps to 0 and state:=WAIT_SWAP.
- WAIT_SWAP:
  - At the first edge with frame_sync=1 (earliest E9), front:=back, frame_counter+=1 (wraps modulo width), state:=IDLE.
  - frame_done=1 for the cycle following that edge.
  - A frame_sync that arrives during IDLE or BUILD is ignored.
  - A frame_sync coincident with the E8 edge is not used; the block waits for the next pulse.
- Front buffer changes only at a swap edge.
- Minimum start-to-visible latency is 9 clocks.
- start may be asserted in the same cycle that frame_done is high (state is IDLE); a new frame begins.

Decomposition:
- tetris_pkg holds:
  - typedef row_t = logic [7:0]
  - typedef frame_t = logic [7:0][7:0]
  - typedef coord_t = logic [2:0]
  - constants ROWS=8, COLS=8, PIECE_CELLS=4
  - enum comp_state_t {IDLE, BUILD, WAIT_SWAP}
- Sub-module row_composer is purely combinational:
  - inputs: row index, locked row, piece arrays, flash bit, blink phase
  - outputs: red row_t and green row_t
- Row counter reuses the existing increment module with WIDTH=3.

Test Plan:
- Reset release, no start -> red_array=green_array=0, busy=0 indefinitely; repeated frame_sync gives no frame_done.
- locked[7]=8'hFF, piece at (x=3,y=0),(4,0),(3,1),(4,1) masked 4'hF, start then frame_sync at E12:
  - red rows 0,1 = 8'h18
  - green row 7 = 8'hFF
  - frame_done high in the cycle after E12
  - outputs unchanged before E12.
- Piece cell at (2,7) over locked[7]=8'hFF -> red[7]=8'h04, green[7]=8'hFF (amber at column 2).
- flash_rows=8'h80, locked[7]=8'hFF, BLINK_LOG2=0, 4 consecutive frames -> green[7] alternates 8'hFF, 8'h00, 8'hFF, 8'h00.
- start pulsed during BUILD and again during WAIT_SWAP -> ignored: exactly one frame_done; inputs changed after E0 do not appear in the output.
- reset_n dropped mid-BUILD at row 4 -> outputs 0 immediately (asynchronous); after release, a full start/frame_sync cycle works normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris display path.
// Row/frame/coordinate typedefs, board geometry, and the compositor FSM states.
package tetris_pkg;
  typedef logic [7:0]      row_t;
  typedef logic [7:0][7:0] frame_t;   // [row][col]
  typedef logic [2:0]      coord_t;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int PIECE_CELLS = 4;

  typedef enum logic [1:0] {IDLE, BUILD, WAIT_SWAP} comp_state_t;
endpackage

// File: rtl/increment.sv
// Generic +1 incrementer, wraps modulo 2^WIDTH.
//   a_i : value in
//   y_o : a_i + 1
module increment #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i + WIDTH'(1);
endmodule

// File: rtl/row_composer.sv
// Combinational composition of one display row.
//   row_i        : row index being composed
//   locked_i     : settled cells of that row -> green plane
//   piece_*_i    : active piece cells; a cell on this row lights red
//   flash_i      : row is being cleared
//   phase_i      : blink phase; a flashing row is blanked while phase is 1
//   red_o/green_o: composed row planes
module row_composer
  import tetris_pkg::*;
(
  input  logic [2:0]      row_i,
  input  logic [7:0]      locked_i,
  input  logic [3:0][2:0] piece_x_i,
  input  logic [3:0][2:0] piece_y_i,
  input  logic [3:0]      piece_mask_i,
  input  logic            flash_i,
  input  logic            phase_i,
  output logic [7:0]      red_o,
  output logic [7:0]      green_o
);
  row_t piece;
  logic blank;

  // Duplicate piece cells simply set the same bit twice.
  always_comb begin
    piece = '0;
    for (int i = 0; i < PIECE_CELLS; i++)
      if (piece_mask_i[i] && piece_y_i[i] == row_i) piece[piece_x_i[i]] = 1'b1;
  end

  assign blank   = flash_i & phase_i;
  // Red and green both set on a cell is the amber collision indicator.
  assign red_o   = blank ? '0 : piece;
  assign green_o = blank ? '0 : locked_i;
endmodule

// File: rtl/frame_compositor.sv
// Composes the red/green 8x8 frame for led_matrix_driver from game state.
// A start in IDLE snapshots the game state, BUILD writes one back-buffer row
// per clock, and WAIT_SWAP copies back->front on the driver's frame_sync so a
// scan never sees a half-built frame.
//   clk, reset_n            : clock, async active-low reset
//   start                   : compose request (only honoured in IDLE)
//   frame_sync              : driver wrap pulse, swap point
//   locked/piece_*/flash_rows : game state inputs
//   busy                    : BUILD or WAIT_SWAP
//   frame_done              : one-cycle pulse after a swap
//   red_array/green_array   : front buffer planes, [row][col]
module frame_compositor
  import tetris_pkg::*;
#(
  parameter int BLINK_LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            frame_sync,
  input  logic [7:0][7:0] locked,
  input  logic [3:0][2:0] piece_x,
  input  logic [3:0][2:0] piece_y,
  input  logic [3:0]      piece_mask,
  input  logic [7:0]      flash_rows,
  output logic            busy,
  output logic            frame_done,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array
);
  typedef logic [BLINK_LOG2:0] fcnt_t;

  comp_state_t     state_q;
  coord_t          row_q, row_d;
  fcnt_t           fcnt_q;
  frame_t          locked_q, back_r_q, back_g_q, front_r_q, front_g_q;
  logic [3:0][2:0] px_q, py_q;
  logic [3:0]      pm_q;
  row_t            flash_q;
  logic            phase_q, done_q;
  row_t            row_red, row_grn;

  increment #(.WIDTH(3)) u_row_inc (.a_i(row_q), .y_o(row_d));

  // Composition reads only the snapshot, never the live inputs.
  row_composer u_row (
    .row_i       (row_q),
    .locked_i    (locked_q[row_q]),
    .piece_x_i   (px_q),
    .piece_y_i   (py_q),
    .piece_mask_i(pm_q),
    .flash_i     (flash_q[row_q]),
    .phase_i     (phase_q),
    .red_o       (row_red),
    .green_o     (row_grn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      fcnt_q    <= '0;
      locked_q  <= '0;
      px_q      <= '0;
      py_q      <= '0;
      pm_q      <= '0;
      flash_q   <= '0;
      phase_q   <= 1'b0;
      back_r_q  <= '0;
      back_g_q  <= '0;
      front_r_q <= '0;
      front_g_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          locked_q <= locked;
          px_q     <= piece_x;
          py_q     <= piece_y;
          pm_q     <= piece_mask;
          flash_q  <= flash_rows;
          phase_q  <= fcnt_q[BLINK_LOG2];
          row_q    <= '0;
          state_q  <= BUILD;
        end
        BUILD: begin
          back_r_q[row_q] <= row_red;
          back_g_q[row_q] <= row_grn;
          row_q           <= row_d;
          if (row_q == 3'd7) state_q <= WAIT_SWAP;
        end
        WAIT_SWAP: if (frame_sync) begin
          front_r_q <= back_r_q;
          front_g_q <= back_g_q;
          fcnt_q    <= fcnt_q + fcnt_t'(1);
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign red_array   = front_r_q;
  assign green_array = front_g_q;
endmodule

// File: tb/tb_frame_compositor.sv
module tb_frame_compositor;
  import tetris_pkg::*;

  localparam int BL = 0;

  logic            clk = 1'b0;
  logic            reset_n, start, frame_sync;
  frame_t          locked;
  logic [3:0][2:0] px, py;
  logic [3:0]      pm;
  row_t            flash;
  logic            busy, frame_done;
  frame_t          red_array, green_array;

  typedef struct packed { frame_t r; frame_t g; } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [BL:0] m_fcnt;

  frame_compositor #(.BLINK_LOG2(BL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_sync(frame_sync),
    .locked(locked), .piece_x(px), .piece_y(py), .piece_mask(pm),
    .flash_rows(flash), .busy(busy), .frame_done(frame_done),
    .red_array(red_array), .green_array(green_array)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference frame from the current inputs and the bench's own frame count.
  function automatic exp_t model();
    exp_t e;
    logic ph;
    ph  = m_fcnt[BL];
    e.g = locked;
    e.r = '0;
    for (int i = 0; i < 4; i++) if (pm[i]) e.r[py[i]][px[i]] = 1'b1;
    for (int r = 0; r < 8; r++) if (flash[r] && ph) begin e.r[r] = '0; e.g[r] = '0; end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start a frame (the next edge is E0) and push its expected result.
  task automatic launch();
    start = 1'b1;
    sb.push_back(model());
    tick();
    start = 1'b0;
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " red"}, red_array, e.r);
      chk({tag, " green"}, green_array, e.g);
    end
    m_fcnt++;
  endtask

  // Pulse frame_sync every cycle until the swap lands (bounded).
  task automatic finish_frame(input string tag);
    for (int k = 0; k < 20; k++) begin
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      if (frame_done) break;
    end
    chk({tag, " done"}, frame_done, 1'b1);
    if (frame_done) check_front(tag);
  endtask

  initial begin
    logic   bad, saw;
    int     extra;
    row_t   tbl [4];
    tbl = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    reset_n = 1'b0; start = 1'b0; frame_sync = 1'b0;
    locked = '0; px = '0; py = '0; pm = '0; flash = '0; m_fcnt = '0;

    // Reset state and idle behaviour
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst red", red_array, 64'd0);
    chk("rst green", green_array, 64'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", frame_done, 1'b0);
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      frame_sync = k[0];
      tick();
      if (frame_done || busy || red_array != '0 || green_array != '0) saw = 1'b1;
    end
    frame_sync = 1'b0;
    chk("idle sync ignored", saw, 1'b0);

    // Frame A: 2x2 piece at top, full locked bottom row, swap at E12
    locked[7] = 8'hFF;
    px = {3'd4, 3'd3, 3'd4, 3'd3};
    py = {3'd1, 3'd1, 3'd0, 3'd0};
    pm = 4'hF;
    launch();
    chk("A busy", busy, 1'b1);
    bad = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (red_array != '0 || green_array != '0 || frame_done) bad = 1'b1;
    end
    chk("A unchanged pre-swap", bad, 1'b0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("A done", frame_done, 1'b1);
    chk("A red0", red_array[0], 8'h18);
    chk("A red1", red_array[1], 8'h18);
    chk("A green7", green_array[7], 8'hFF);
    check_front("A");

    // Frame B started in the frame_done cycle; amber at (2,7); sync at E8 ignored
    locked = '0; locked[7] = 8'hFF;
    px = '0; py = '0; px[0] = 3'd2; py[0] = 3'd7; pm = 4'b0001;
    launch();
    chk("B busy", busy, 1'b1);
    repeat (7) tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick(); tick();
    chk("B E8 sync ignored", frame_done, 1'b0);
    chk("B still busy", busy, 1'b1);
    chk("B front held", red_array[0], 8'h18);
    finish_frame("B");
    chk("B red7", red_array[7], 8'h04);
    chk("B green7", green_array[7], 8'hFF);

    // Blink: flashing row 7 alternates per swapped frame
    locked = '0; locked[7] = 8'hFF; pm = '0; flash = 8'h80;
    for (int f = 0; f < 4; f++) begin
      launch();
      finish_frame("blink");
      chk("blink green7", green_array[7], tbl[f]);
    end

    // Start ignored while busy; post-E0 input changes ignored
    flash = '0;
    for (int r = 0; r < 8; r++) locked[r] = 8'(r * 17 + 1);
    px = {3'd7, 3'd5, 3'd1, 3'd0}; py = {3'd6, 3'd4, 3'd2, 3'd0}; pm = 4'hF;
    launch();
    locked = '1; pm = '0; flash = '1;
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("C busy in wait", busy, 1'b1);
    finish_frame("C");
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      if (frame_done) extra++;
    end
    chk("C extra frame_done", 32'(extra), 32'd0);
    chk("C idle after", busy, 1'b0);

    // Asynchronous reset mid-BUILD at row 4
    locked = '0; locked[3] = 8'h3C; pm = '0; flash = '0;
    launch();
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async rst red", red_array, 64'd0);
    chk("async rst green", green_array, 64'd0);
    chk("async rst busy", busy, 1'b0);
    sb.delete();
    m_fcnt = '0;
    tick();
    reset_n = 1'b1;
    tick();
    locked = '0; locked[2] = 8'hA5;
    px = '0; py = '0; px[1] = 3'd6; py[1] = 3'd5; pm = 4'b0010;
    launch();
    finish_frame("post-rst");
    chk("post-rst red5", red_array[5], 8'h40);
    chk("post-rst green2", green_array[2], 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
